// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension slice.
// Contents:
//   imm_mode_e  - 2-bit extension mode (SIGN, ZERO, UPPER, SHL2)
//   IMM_MODE_W  - width of the mode field
package imm_ext_pkg;

  localparam int unsigned IMM_MODE_W = 2;

  typedef enum logic [IMM_MODE_W-1:0] {
    ModeSign  = 2'b00,
    ModeZero  = 2'b01,
    ModeUpper = 2'b10,
    ModeShl2  = 2'b11
  } imm_mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender.
// Parameters:
//   IN_W  - raw immediate width
//   OUT_W - extended result width (must be at least IN_W+2)
// Ports:
//   i_imm  [IN_W-1:0]  raw immediate field
//   i_mode [1:0]       extension mode (imm_mode_e encoding)
//   o_ext  [OUT_W-1:0] extended result
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]       i_imm,
  input  logic [IMM_MODE_W-1:0] i_mode,
  output logic [OUT_W-1:0]      o_ext
);

  // SHL2 drops the top two bits of the sign-extended value, so at least two
  // bits of headroom above the immediate are required.
  if (OUT_W < IN_W + 2) begin : g_bad_width
    $error("imm_ext_core: OUT_W (%0d) must be >= IN_W+2 (%0d)", OUT_W, IN_W + 2);
  end

  logic [OUT_W-1:0] w_sign;
  logic [OUT_W-1:0] w_zero;
  logic [OUT_W-1:0] w_upper;
  logic [OUT_W-1:0] w_shl2;

  assign w_sign  = {{(OUT_W - IN_W){i_imm[IN_W-1]}}, i_imm};
  assign w_zero  = {{(OUT_W - IN_W){1'b0}}, i_imm};
  assign w_upper = {i_imm, {(OUT_W - IN_W){1'b0}}};
  assign w_shl2  = {w_sign[OUT_W-3:0], 2'b00};

  always_comb begin
    o_ext = '0;
    unique case (imm_mode_e'(i_mode))
      ModeSign:  o_ext = w_sign;
      ModeZero:  o_ext = w_zero;
      ModeUpper: o_ext = w_upper;
      ModeShl2:  o_ext = w_shl2;
      default:   o_ext = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage with a two-entry skid buffer.
// The extension is computed at the input; the stage only stores results.
// in_ready comes straight from the skid-valid flop, so there is no
// combinational path from out_ready to in_ready.
// Parameters:
//   IN_W  - raw immediate width
//   OUT_W - extended result width (>= IN_W+2)
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_imm, in_mode     raw immediate and extension mode
//   out_valid/out_ready output handshake
//   out_ext             extended result (from the main register)
module imm_extend_stage
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_imm,
  input  logic [IMM_MODE_W-1:0] in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_ext
);

  logic [OUT_W-1:0] w_ext;
  logic             w_in_xfer;
  logic             w_out_xfer;

  logic             r_main_valid;
  logic [OUT_W-1:0] r_main_data;
  logic             r_skid_valid;
  logic [OUT_W-1:0] r_skid_data;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .i_imm  (in_imm),
    .i_mode (in_mode),
    .o_ext  (w_ext)
  );

  assign w_in_xfer  = in_valid && !r_skid_valid;
  assign w_out_xfer = r_main_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (w_out_xfer) begin
      if (r_skid_valid) begin
        // in_ready is low while skid is full, so no input can arrive here.
        r_main_data  <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else if (w_in_xfer) begin
        r_main_data  <= w_ext;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_in_xfer) begin
      if (!r_main_valid) begin
        r_main_valid <= 1'b1;
        r_main_data  <= w_ext;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_ext;
      end
    end
  end

  assign in_ready  = !r_skid_valid;
  assign out_valid = r_main_valid;
  assign out_ext   = r_main_data;

endmodule

// File: tb/tb_imm_extend_stage.sv
module tb_imm_extend_stage;

  logic        clk;
  logic        rst_n;

  logic        a_in_valid;
  logic        a_in_ready;
  logic [15:0] a_in_imm;
  logic [1:0]  a_in_mode;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [31:0] a_out_ext;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [11:0] b_in_imm;
  logic [1:0]  b_in_mode;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [31:0] b_out_ext;

  int n_checks;
  int n_errors;

  imm_extend_stage #(
    .IN_W  (16),
    .OUT_W (32)
  ) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_imm    (a_in_imm),
    .in_mode   (a_in_mode),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_ext   (a_out_ext)
  );

  imm_extend_stage #(
    .IN_W  (12),
    .OUT_W (32)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_imm    (b_in_imm),
    .in_mode   (b_in_mode),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_ext   (b_out_ext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one input for one edge into dut_a, then check the registered result.
  task automatic send_a(input logic [1:0] mode, input logic [15:0] imm, input logic [31:0] exp,
                        input int idx);
    a_in_valid = 1'b1;
    a_in_mode  = mode;
    a_in_imm   = imm;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    check($sformatf("vec%0d_valid", idx), {31'd0, a_out_valid}, 32'd1);
    check($sformatf("vec%0d_ext", idx), a_out_ext, exp);
  endtask

  task automatic send_b(input logic [1:0] mode, input logic [11:0] imm, input logic [31:0] exp,
                        input string name);
    b_in_valid = 1'b1;
    b_in_mode  = mode;
    b_in_imm   = imm;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    check({name, "_valid"}, {31'd0, b_out_valid}, 32'd1);
    check(name, b_out_ext, exp);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{2'b00, 16'h8001, 32'hFFFF8001};
    vecs[1] = '{2'b01, 16'h8001, 32'h00008001};
    vecs[2] = '{2'b10, 16'h8001, 32'h80010000};
    vecs[3] = '{2'b11, 16'h8001, 32'hFFFE0004};
    vecs[4] = '{2'b00, 16'h7FFF, 32'h00007FFF};
    vecs[5] = '{2'b11, 16'h7FFF, 32'h0001FFFC};
    vecs[6] = '{2'b01, 16'hFFFF, 32'h0000FFFF};
    vecs[7] = '{2'b10, 16'h0001, 32'h00010000};
    vecs[8] = '{2'b11, 16'h0000, 32'h00000000};
    vecs[9] = '{2'b00, 16'hC000, 32'hFFFFC000};

    rst_n       = 1'b0;
    a_in_valid  = 1'b0;
    a_in_imm    = '0;
    a_in_mode   = '0;
    a_out_ready = 1'b1;
    b_in_valid  = 1'b0;
    b_in_imm    = '0;
    b_in_mode   = '0;
    b_out_ready = 1'b1;

    #1;
    check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst_out_ext", a_out_ext, 32'd0);
    check("rst_in_ready", {31'd0, a_in_ready}, 32'd1);

    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("post_rst_in_ready", {31'd0, a_in_ready}, 32'd1);

    // Table-driven mode coverage, out_ready held high.
    for (int i = 0; i < 10; i++) begin
      send_a(vecs[i].mode, vecs[i].imm, vecs[i].exp, i);
    end
    @(posedge clk);
    #1;
    check("drain_out_valid", {31'd0, a_out_valid}, 32'd0);

    // 12-bit immediate instance.
    send_b(2'b00, 12'h800, 32'hFFFFF800, "w12_sign");
    send_b(2'b10, 12'h800, 32'h80000000, "w12_upper");
    send_b(2'b01, 12'h800, 32'h00000800, "w12_zero");
    send_b(2'b11, 12'h800, 32'hFFFFE000, "w12_shl2");

    // Back-pressure: fill main and skid, third input must stall.
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_mode   = 2'b00;
    a_in_imm    = 16'h0001;
    @(posedge clk);
    #1;
    check("bp_first_ext", a_out_ext, 32'h1);
    check("bp_first_ready", {31'd0, a_in_ready}, 32'd1);
    a_in_imm = 16'h0002;
    @(posedge clk);
    #1;
    check("bp_full_ready", {31'd0, a_in_ready}, 32'd0);
    check("bp_hold_ext", a_out_ext, 32'h1);
    a_in_imm = 16'h0003;
    @(posedge clk);
    #1;
    check("bp_stall_ready", {31'd0, a_in_ready}, 32'd0);
    check("bp_stall_ext", a_out_ext, 32'h1);
    check("bp_stall_valid", {31'd0, a_out_valid}, 32'd1);
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_second_ext", a_out_ext, 32'h2);
    check("bp_ready_back", {31'd0, a_in_ready}, 32'd1);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    check("bp_third_ext", a_out_ext, 32'h3);
    check("bp_third_valid", {31'd0, a_out_valid}, 32'd1);
    @(posedge clk);
    #1;
    check("bp_empty_valid", {31'd0, a_out_valid}, 32'd0);

    // Streaming: one result per cycle, in_ready never drops.
    a_in_valid = 1'b1;
    a_in_mode  = 2'b01;
    for (int i = 0; i < 8; i++) begin
      a_in_imm = 16'h0010 + 16'(i);
      @(posedge clk);
      #1;
      check($sformatf("stream%0d_ext", i), a_out_ext, 32'h10 + 32'(i));
      check($sformatf("stream%0d_valid", i), {31'd0, a_out_valid}, 32'd1);
      check($sformatf("stream%0d_ready", i), {31'd0, a_in_ready}, 32'd1);
    end
    a_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("stream_drain_valid", {31'd0, a_out_valid}, 32'd0);

    // Reset with both registers full.
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_mode   = 2'b00;
    a_in_imm    = 16'hAAAA;
    @(posedge clk);
    #1;
    a_in_imm = 16'hBBBB;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    check("pre_rst_full", {31'd0, a_in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("mid_rst_out_ext", a_out_ext, 32'd0);
    check("mid_rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("after_rst_valid", {31'd0, a_out_valid}, 32'd0);
    send_a(2'b01, 16'h0055, 32'h00000055, 100);
    @(posedge clk);
    #1;
    check("after_rst_no_stale", {31'd0, a_out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
